// File: rtl/tdm_pkg.sv
// Shared types and default sizing for the TDM demux accumulator.
// No logic here; there is no latency and no backpressure.
package tdm_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_BURST_LEN  = 16;

    typedef enum logic {
        HUNT,
        RUN
    } in_state_t;

    typedef enum logic {
        EMPTY,
        DRAIN
    } out_state_t;

endpackage

// File: rtl/tdm_demux_accum_if.sv
// Sample-in / burst-sum-out bundle for tdm_demux_accum.
// Wires only; there is no latency. dout_valid/dout_ready form the output handshake.
interface tdm_demux_accum_if
    import tdm_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int BURST_LEN  = DEF_BURST_LEN
);
    localparam int ACC_WIDTH = DATA_WIDTH + $clog2(BURST_LEN);
    localparam int CH_W      = $clog2(NUM_CH);

    logic [DATA_WIDTH-1:0] din;
    logic                  din_valid;
    logic                  sof;
    logic [ACC_WIDTH-1:0]  dout_data;
    logic [CH_W-1:0]       dout_ch;
    logic                  dout_valid;
    logic                  dout_ready;
    logic                  overflow;
    logic                  sync_err;

    modport master (
        output din, din_valid, sof, dout_ready,
        input  dout_data, dout_ch, dout_valid, overflow, sync_err
    );

    modport slave (
        input  din, din_valid, sof, dout_ready,
        output dout_data, dout_ch, dout_valid, overflow, sync_err
    );

endinterface

// File: rtl/tdm_burst_buf.sv
// Holds one completed burst and drains it one channel per accepted cycle.
// Latency: 1 cycle from burst_vld to dout_valid. A burst that arrives while draining is dropped and flagged.
module tdm_burst_buf
    import tdm_pkg::*;
#(
    parameter int ACC_WIDTH = 20,
    parameter int NUM_CH    = DEF_NUM_CH,
    localparam int CH_W     = $clog2(NUM_CH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             burst_vld,
    input  logic [NUM_CH-1:0][ACC_WIDTH-1:0] burst_dat,
    output logic [ACC_WIDTH-1:0]             dout_data,
    output logic [CH_W-1:0]                  dout_ch,
    output logic                             dout_valid,
    input  logic                             dout_ready,
    output logic                             overflow
);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    out_state_t                       out_q, out_d;
    logic [CH_W-1:0]                  ch_q, ch_d;
    logic [NUM_CH-1:0][ACC_WIDTH-1:0] buf_q, buf_d;
    logic                             ovf_q, ovf_d;
    logic                             drain_done;

    always_comb begin
        out_d      = out_q;
        ch_d       = ch_q;
        buf_d      = buf_q;
        ovf_d      = ovf_q;
        drain_done = 1'b0;

        if (out_q == DRAIN && dout_ready) begin
            if (ch_q == LAST_CH) begin
                drain_done = 1'b1;
                out_d      = EMPTY;
                ch_d       = '0;
            end else begin
                ch_d = ch_q + 1'b1;
            end
        end

        // The buffer frees up on the same edge the last channel leaves, so a new burst can land then.
        if (burst_vld) begin
            if (out_q == EMPTY || drain_done) begin
                buf_d = burst_dat;
                out_d = DRAIN;
                ch_d  = '0;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= EMPTY;
            ch_q  <= '0;
            buf_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ch_q  <= ch_d;
            buf_q <= buf_d;
            ovf_q <= ovf_d;
        end
    end

    assign dout_valid = (out_q == DRAIN);
    assign dout_ch    = ch_q;
    assign dout_data  = buf_q[ch_q];
    assign overflow   = ovf_q;

endmodule

// File: rtl/tdm_demux_accum.sv
// Demultiplexes a TDM sample stream by slot and sums BURST_LEN frames per channel.
// Latency: sums valid the cycle after the last sample of a burst. Input never stalls; bursts are dropped if output is busy.
module tdm_demux_accum
    import tdm_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int BURST_LEN  = DEF_BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    tdm_demux_accum_if.slave  bus
);
    localparam int ACC_WIDTH = DATA_WIDTH + $clog2(BURST_LEN);
    localparam int CH_W      = $clog2(NUM_CH);
    localparam int FR_W      = $clog2(BURST_LEN);

    localparam logic [CH_W-1:0] LAST_SLOT  = CH_W'(NUM_CH - 1);
    localparam logic [FR_W-1:0] LAST_FRAME = FR_W'(BURST_LEN - 1);

    in_state_t                        in_q, in_d;
    logic [CH_W-1:0]                  slot_q, slot_d;
    logic [FR_W-1:0]                  frame_q, frame_d;
    logic [NUM_CH-1:0][ACC_WIDTH-1:0] acc_q, acc_d;
    logic                             sync_err_q, sync_err_d;
    logic                             burst_vld;
    logic [ACC_WIDTH-1:0]             din_ext;

    assign din_ext = ACC_WIDTH'(bus.din);

    always_comb begin
        in_d       = in_q;
        slot_d     = slot_q;
        frame_d    = frame_q;
        acc_d      = acc_q;
        sync_err_d = sync_err_q;
        burst_vld  = 1'b0;

        if (bus.din_valid) begin
            if (bus.sof && (in_q == HUNT || slot_q != '0)) begin
                // Stale partial sums in other slots are overwritten because frame 0 loads instead of adds.
                if (in_q == RUN) begin
                    sync_err_d = 1'b1;
                end
                in_d     = RUN;
                acc_d[0] = din_ext;
                slot_d   = CH_W'(1);
                frame_d  = '0;
            end else if (in_q == RUN) begin
                acc_d[slot_q] = (frame_q == '0) ? din_ext : acc_q[slot_q] + din_ext;
                if (slot_q == LAST_SLOT) begin
                    slot_d = '0;
                    if (frame_q == LAST_FRAME) begin
                        frame_d   = '0;
                        burst_vld = 1'b1;
                    end else begin
                        frame_d = frame_q + 1'b1;
                    end
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q       <= HUNT;
            slot_q     <= '0;
            frame_q    <= '0;
            acc_q      <= '0;
            sync_err_q <= 1'b0;
        end else begin
            in_q       <= in_d;
            slot_q     <= slot_d;
            frame_q    <= frame_d;
            acc_q      <= acc_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign bus.sync_err = sync_err_q;

    // acc_d already contains the final sample, so the buffer captures complete sums on this edge.
    tdm_burst_buf #(
        .ACC_WIDTH (ACC_WIDTH),
        .NUM_CH    (NUM_CH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .burst_vld  (burst_vld),
        .burst_dat  (acc_d),
        .dout_data  (bus.dout_data),
        .dout_ch    (bus.dout_ch),
        .dout_valid (bus.dout_valid),
        .dout_ready (bus.dout_ready),
        .overflow   (bus.overflow)
    );

endmodule

// File: tb/tb_tdm_demux_accum.sv
// Directed bench for tdm_demux_accum with NUM_CH=2, BURST_LEN=4, DATA_WIDTH=16.
module tb_tdm_demux_accum;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    tdm_demux_accum_if #(.DATA_WIDTH(16), .NUM_CH(2), .BURST_LEN(4)) bus ();

    tdm_demux_accum #(.DATA_WIDTH(16), .NUM_CH(2), .BURST_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        v;
        logic        s;
        logic [15:0] d;
        logic        r;
        logic        ev;
        logic        ech;
        logic [17:0] edat;
        logic        eovf;
        logic        eserr;
    } vec_t;

    vec_t tbl [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [15:0] d, input logic r);
        bus.din_valid  = v;
        bus.sof        = s;
        bus.din        = d;
        bus.dout_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.din_valid  = 1'b0;
        bus.sof        = 1'b0;
        bus.din        = '0;
        bus.dout_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_out(input string name, input logic ev, input logic ech, input logic [17:0] edat);
        chk({name, " valid"}, 32'(bus.dout_valid), 32'(ev));
        if (ev) begin
            chk({name, " ch"}, 32'(bus.dout_ch), 32'(ech));
            chk({name, " data"}, 32'(bus.dout_data), 32'(edat));
        end
    endtask

    // ch0 gets k*1..k*4, ch1 gets k*10..k*40, so sums are 10k and 100k.
    task automatic send_burst(input int k, input logic with_sof, input logic r);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, with_sof && (i == 0), 16'(k * (i + 1)), r);
            drive(1'b1, 1'b0, 16'(k * 10 * (i + 1)), r);
        end
    endtask

    initial begin
        bus.din_valid  = 1'b0;
        bus.sof        = 1'b0;
        bus.din        = '0;
        bus.dout_ready = 1'b1;
        #2;
        chk("reset valid", 32'(bus.dout_valid), 32'd0);
        chk("reset ch", 32'(bus.dout_ch), 32'd0);
        chk("reset data", 32'(bus.dout_data), 32'd0);
        chk("reset overflow", 32'(bus.overflow), 32'd0);
        chk("reset sync_err", 32'(bus.sync_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // basic burst, then sof at slot 0 (silent), then sof at slot 1 (sync error and restart)
        tbl[0]  = '{1'b1, 1'b1, 16'd1,  1'b1, 1'b0, 1'b0, 18'd0,   1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 16'd10, 1'b1, 1'b0, 1'b0, 18'd0,   1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 16'd2,  1'b1, 1'b0, 1'b0, 18'd0,   1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 16'd20, 1'b1, 1'b0, 1'b0, 18'd0,   1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 16'd3,  1'b1, 1'b0, 1'b0, 18'd0,   1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 16'd30, 1'b1, 1'b0, 1'b0, 18'd0,   1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 16'd4,  1'b1, 1'b0, 1'b0, 18'd0,   1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 16'd40, 1'b1, 1'b1, 1'b0, 18'd10,  1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 16'd0,  1'b1, 1'b1, 1'b1, 18'd100, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 18'd0,   1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 16'd5,  1'b1, 1'b0, 1'b0, 18'd0,   1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 16'd6,  1'b1, 1'b0, 1'b0, 18'd0,   1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 16'd7,  1'b1, 1'b0, 1'b0, 18'd0,   1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 16'd1,  1'b1, 1'b0, 1'b0, 18'd0,   1'b0, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 16'd10, 1'b1, 1'b0, 1'b0, 18'd0,   1'b0, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 16'd2,  1'b1, 1'b0, 1'b0, 18'd0,   1'b0, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 16'd20, 1'b1, 1'b0, 1'b0, 18'd0,   1'b0, 1'b1};
        tbl[17] = '{1'b1, 1'b0, 16'd3,  1'b1, 1'b0, 1'b0, 18'd0,   1'b0, 1'b1};
        tbl[18] = '{1'b1, 1'b0, 16'd30, 1'b1, 1'b0, 1'b0, 18'd0,   1'b0, 1'b1};
        tbl[19] = '{1'b1, 1'b0, 16'd4,  1'b1, 1'b0, 1'b0, 18'd0,   1'b0, 1'b1};
        tbl[20] = '{1'b1, 1'b0, 16'd40, 1'b1, 1'b1, 1'b0, 18'd10,  1'b0, 1'b1};
        tbl[21] = '{1'b0, 1'b0, 16'd0,  1'b1, 1'b1, 1'b1, 18'd100, 1'b0, 1'b1};
        tbl[22] = '{1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 18'd0,   1'b0, 1'b1};

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r);
            chk_out($sformatf("row%0d", i), tbl[i].ev, tbl[i].ech, tbl[i].edat);
            chk($sformatf("row%0d overflow", i), 32'(bus.overflow), 32'(tbl[i].eovf));
            chk($sformatf("row%0d sync_err", i), 32'(bus.sync_err), 32'(tbl[i].eserr));
        end

        // stall: ch0 word held for 5 cycles, then drains normally
        do_reset();
        send_burst(1, 1'b1, 1'b0);
        chk_out("stall first", 1'b1, 1'b0, 18'd10);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 16'd0, 1'b0);
            chk_out($sformatf("stall hold%0d", i), 1'b1, 1'b0, 18'd10);
        end
        drive(1'b0, 1'b0, 16'd0, 1'b1);
        chk_out("stall ch1", 1'b1, 1'b1, 18'd100);
        drive(1'b0, 1'b0, 16'd0, 1'b1);
        chk_out("stall end", 1'b0, 1'b0, 18'd0);
        chk("stall overflow", 32'(bus.overflow), 32'd0);

        // back-to-back bursts with output stalled: second dropped
        do_reset();
        send_burst(1, 1'b1, 1'b0);
        send_burst(2, 1'b0, 1'b0);
        chk("ovf flag", 32'(bus.overflow), 32'd1);
        chk_out("ovf held", 1'b1, 1'b0, 18'd10);
        drive(1'b0, 1'b0, 16'd0, 1'b1);
        chk_out("ovf ch1", 1'b1, 1'b1, 18'd100);
        drive(1'b0, 1'b0, 16'd0, 1'b1);
        chk_out("ovf end", 1'b0, 1'b0, 18'd0);
        drive(1'b0, 1'b0, 16'd0, 1'b1);
        chk_out("ovf none", 1'b0, 1'b0, 18'd0);
        chk("ovf sticky", 32'(bus.overflow), 32'd1);

        // burst completes the same cycle the final channel is accepted
        do_reset();
        send_burst(1, 1'b1, 1'b0);
        for (int j = 0; j < 8; j++) begin
            drive(1'b1, 1'b0, (j % 2 == 0) ? 16'(2 * (j / 2 + 1)) : 16'(20 * (j / 2 + 1)), j >= 6);
        end
        chk_out("handoff restart", 1'b1, 1'b0, 18'd20);
        chk("handoff overflow", 32'(bus.overflow), 32'd0);
        drive(1'b0, 1'b0, 16'd0, 1'b1);
        chk_out("handoff ch1", 1'b1, 1'b1, 18'd200);
        drive(1'b0, 1'b0, 16'd0, 1'b1);
        chk_out("handoff end", 1'b0, 1'b0, 18'd0);

        // full-scale samples: sums must reach 4*0xFFFF without wrapping
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i == 0, 16'hFFFF, 1'b1);
            if (i == 7 || i == 15) chk_out($sformatf("max s%0d", i), 1'b1, 1'b0, 18'h3FFFC);
            if (i == 8) chk_out("max s8", 1'b1, 1'b1, 18'h3FFFC);
        end
        drive(1'b0, 1'b0, 16'd0, 1'b1);
        chk_out("max last", 1'b1, 1'b1, 18'h3FFFC);
        chk("max overflow", 32'(bus.overflow), 32'd0);

        // reset mid-drain, then samples without sof are ignored
        do_reset();
        send_burst(1, 1'b1, 1'b0);
        chk_out("mid pre", 1'b1, 1'b0, 18'd10);
        rst = 1'b1;
        #1;
        chk("mid rst valid", 32'(bus.dout_valid), 32'd0);
        chk("mid rst ch", 32'(bus.dout_ch), 32'd0);
        chk("mid rst data", 32'(bus.dout_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 16'(i + 7), 1'b1);
            chk_out($sformatf("nosof%0d", i), 1'b0, 1'b0, 18'd0);
        end
        drive(1'b0, 1'b0, 16'd0, 1'b1);
        chk_out("nosof idle", 1'b0, 1'b0, 18'd0);
        send_burst(3, 1'b1, 1'b1);
        chk_out("after sof", 1'b1, 1'b0, 18'd30);
        drive(1'b0, 1'b0, 16'd0, 1'b1);
        chk_out("after sof ch1", 1'b1, 1'b1, 18'd300);
        chk("after sof overflow", 32'(bus.overflow), 32'd0);
        chk("after sof sync_err", 32'(bus.sync_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tdm_demux_accum.md
TDM_DEMUX_ACCUM -- requirements
Module: tdm_demux_accum

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of the time-multiplexed product sample.
REQ-002 SHALL have parameter NUM_CH, default 2: number of TDM slots (channels), at least 2.
REQ-003 SHALL have parameter BURST_LEN, default 16: number of complete frames summed per channel per burst, at least 2.
REQ-004 SHALL have localparam ACC_WIDTH = DATA_WIDTH + clog2(BURST_LEN), and localparam CH_W = clog2(NUM_CH).
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port din, input, DATA_WIDTH bits: unsigned product sample from the upstream multiplier.
REQ-008 SHALL have port din_valid, input, 1 bit: din is a valid sample this cycle.
REQ-009 SHALL have port sof, input, 1 bit: qualified by din_valid; marks the sample as slot 0.
REQ-010 SHALL have port dout_data, output, ACC_WIDTH bits: per-channel burst sum.
REQ-011 SHALL have port dout_ch, output, CH_W bits: channel of dout_data.
REQ-012 SHALL have port dout_valid, output, 1 bit: dout_data and dout_ch are valid.
REQ-013 SHALL have port dout_ready, input, 1 bit: downstream accepts the output word.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag, a burst was dropped.
REQ-015 SHALL have port sync_err, output, 1 bit: sticky flag, sof arrived with slot not equal to 0.

Function
REQ-016 Input FSM SHALL have two states. HUNT ignores samples until din_valid&&sof, then goes to RUN with that sample as slot 0. RUN accumulates samples.
REQ-017 In RUN, the slot counter SHALL advance on each din_valid and wrap NUM_CH-1 to 0. The frame counter SHALL advance when slot NUM_CH-1 is accepted.
REQ-018 Each accepted sample SHALL be added zero-extended into acc[slot]. The first sample of a burst SHALL load the accumulator rather than add. No saturation is needed, because the width is sufficient.
REQ-019 When slot NUM_CH-1 of frame BURST_LEN-1 is accepted at cycle N:
- the completed sums (including that sample) SHALL be copied into the output buffer at edge N+1;
- the frame counter SHALL reset;
- the next sample SHALL start a new burst with no gap cycle.
REQ-020 If din_valid&&sof arrives in RUN while slot is not 0:
- sync_err SHALL be set;
- the partial burst SHALL be discarded;
- the sample SHALL start a new burst as slot 0.
REQ-021 sof arriving at slot 0 SHALL be accepted silently.
REQ-022 Output FSM SHALL have two states, EMPTY and DRAIN. A burst handoff moves it to DRAIN with dout_valid=1 and dout_ch=0 at cycle N+1.
REQ-023 In DRAIN, each cycle with dout_valid&&dout_ready SHALL advance dout_ch. Acceptance of channel NUM_CH-1 SHALL return the FSM to EMPTY, with dout_valid low the next cycle.
REQ-024 dout_data and dout_ch SHALL stay stable while dout_valid&&!dout_ready.
REQ-025 If a burst completes while the output FSM is in DRAIN:
- the new burst SHALL be dropped and overflow set;
- the buffer in progress SHALL be unaffected;
- accumulation SHALL continue.
REQ-026 If a burst completes in the same cycle the final channel is accepted, the handoff SHALL succeed with no overflow, and DRAIN SHALL restart at ch 0.
REQ-027 din_valid low SHALL hold all input-side state.
REQ-028 Sticky flags SHALL clear only on rst.

Reset
REQ-029 On rst assertion, the block SHALL immediately enter HUNT and EMPTY, with dout_valid=0, dout_ch=0, dout_data=0, overflow=0, sync_err=0, and slot, frame and accumulators cleared.
REQ-030 Reset mid-burst or mid-drain SHALL discard all data. After release, nothing SHALL be accumulated before the next sof.

Structure
REQ-031 Package tdm_pkg SHALL hold the in_state_t {HUNT, RUN} and out_state_t {EMPTY, DRAIN} enums and the default NUM_CH and BURST_LEN constants.
REQ-032 The output buffer plus drain FSM SHALL be sub-module tdm_burst_buf.

Verification (NUM_CH=2, BURST_LEN=4)
REQ-033 Stimulus: sof, then ch0 1,2,3,4 and ch1 10,20,30,40 interleaved, with dout_ready=1. Response: (ch0,10) at N+1, then (ch1,100) at N+2.
REQ-034 Stimulus: the same burst with dout_ready=0 for 5 cycles. Response: (ch0,10) held stable for 5 cycles, then the drain completes with no overflow.
REQ-035 Stimulus: dout_ready=0 through two back-to-back bursts. Response: overflow=1 and only the first burst is emitted.
REQ-036 Stimulus: sof at slot 1 after 3 samples. Response: sync_err=1; the next burst sums only samples from the new sof.
REQ-037 Stimulus: 16 samples of 0xFFFF. Response: both sums are 0x3FFFC, with no wrap.
REQ-038 Stimulus: rst asserted mid-drain, then samples without sof. Response: dout_valid=0 immediately and no output until after a sof.
